// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display paths (score and timer).
// Segment patterns are active-low, bit order gfedcba.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_for(input int unsigned digits);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    localparam int unsigned MAX_VALUE = max_for(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_encoder.sv
// One BCD digit to an active-low gfedcba pattern; non-decimal nibbles and
// an explicit blank request both produce an unlit digit.
module seg7_encoder
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] segs_o
);

    // NOTE: every path assigns segs_o (default arm included), so no latch is inferred.
    always_comb begin
        segs_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'd0:    segs_o = SEG_0;
                4'd1:    segs_o = SEG_1;
                4'd2:    segs_o = SEG_2;
                4'd3:    segs_o = SEG_3;
                4'd4:    segs_o = SEG_4;
                4'd5:    segs_o = SEG_5;
                4'd6:    segs_o = SEG_6;
                4'd7:    segs_o = SEG_7;
                4'd8:    segs_o = SEG_8;
                4'd9:    segs_o = SEG_9;
                default: segs_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_bcd_display.sv
// Serial double-dabble binary-to-BCD converter feeding four seven-segment
// displays; one operand bit per clock, with a one-deep pending request slot.
module score_bcd_display
    import display_pkg::*;
#(
    parameter int WIDTH               = 14,
    parameter int DIGITS              = 4,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  value_valid,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex_segs
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT      = WIDTH'(max_for(DIGITS));

    function automatic logic [SW-1:0] reset_hex();
        logic [SW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = (i == 0 || BLANK_LEADING_ZEROS == 0) ? SEG_0 : SEG_BLANK;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] HEX_RESET = reset_hex();

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [BW-1:0]    scr_q, scr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pval_q, pval_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [SW-1:0]    hex_q, hex_d;
    logic             done_q, done_d;

    logic [BW-1:0]     adj;
    logic [DIGITS-1:0] blank;
    logic [SW-1:0]     enc_segs;
    logic              request;

    assign request = value_valid || pend_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (request) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every scratch nibble before the shift.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
    end

    // A digit blanks only when it and everything above it are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (scr_q[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LEADING_ZEROS != 0) && (i != 0) && zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encoder u_enc (
            .nibble_i (scr_q[4*g +: 4]),
            .blank_i  (blank[g]),
            .segs_o   (enc_segs[7*g +: 7])
        );
    end

    // Output and datapath next-state logic.
    always_comb begin
        op_d   = op_q;
        scr_d  = scr_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        pval_d = pval_q;
        bcd_d  = bcd_q;
        hex_d  = hex_q;
        done_d = 1'b0;
        busy   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (request) begin
                    if (value_valid) op_d = (value > SAT) ? SAT : value;
                    else             op_d = (pval_q > SAT) ? SAT : pval_q;
                    scr_d  = '0;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end
            end
            SHIFT: begin
                scr_d = (adj << 1) | BW'(op_q[WIDTH-1]);
                op_d  = op_q << 1;
                cnt_d = cnt_q + CW'(1);
            end
            DONE: begin
                bcd_d  = scr_q;
                hex_d  = enc_segs;
                done_d = 1'b1;
            end
            default: ;
        endcase

        // Requests arriving mid-conversion wait; the newest one wins.
        if (value_valid && state_q != IDLE) begin
            pend_d = 1'b1;
            pval_d = value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            scr_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            pval_q <= '0;
            bcd_q  <= '0;
            hex_q  <= HEX_RESET;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            scr_q  <= scr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            pval_q <= pval_d;
            bcd_q  <= bcd_d;
            hex_q  <= hex_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign bcd      = bcd_q;
    assign hex_segs = hex_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display: expected results are queued when a
// request is driven and compared (value and arrival cycle) on each done pulse.
module tb_score_bcd_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] value = '0;
    logic        value_valid = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [27:0] hex_segs;

    typedef struct {
        logic [15:0] bcd;
        logic [27:0] hex;
        int          due;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    localparam logic [27:0] HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};

    score_bcd_display dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .hex_segs    (hex_segs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic sb_t model(input int v, input int due);
        sb_t r;
        int  s, p, d;
        bit  hz;
        s  = (v > 9999) ? 9999 : v;
        p  = 1000;
        hz = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            d = (s / p) % 10;
            p = p / 10;
            r.bcd[4*i +: 4] = 4'(d);
            if (d != 0) hz = 1'b0;
            r.hex[7*i +: 7] = (i != 0 && hz) ? 7'h7F : seg_tab[d];
        end
        r.due = due;
        return r;
    endfunction

    // Drive a one-cycle request; k is the clock edge that samples it.
    task automatic pulse(input int v, output int k);
        @(negedge clk);
        value       = 14'(v);
        value_valid = 1'b1;
        k           = cyc + 1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bcd"}, bcd, 0);
        check({tag, "_hex"}, hex_segs, HEX_RST);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", done, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("bcd", bcd, e.bcd);
                check("hex", hex_segs, e.hex);
                check("latency", cyc, e.due);
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        int vals[7] = '{16383, 7, 0, 9999, 10000, 10, 905};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic conversion with latency and busy window.
        pulse(1234, k);
        sb.push_back(model(1234, k + 15));
        check("busy_start", busy, 1);
        repeat (13) @(negedge clk);
        check("busy_late", busy, 1);
        wait_drain(40);
        check("hex_1234", hex_segs, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        check("bcd_hold", bcd, 16'h1234);

        // Saturation, blanking and boundaries.
        foreach (vals[i]) begin
            pulse(vals[i], k);
            sb.push_back(model(vals[i], k + 15));
            wait_drain(40);
        end
        pulse(16383, k);
        sb.push_back(model(16383, k + 15));
        wait_drain(40);
        check("hex_sat", hex_segs, {4{7'b0010000}});

        repeat (6) begin
            int v;
            v = int'($urandom_range(0, 16383));
            pulse(v, k);
            sb.push_back(model(v, k + 15));
            wait_drain(40);
        end

        // Requests while busy: 200 is overwritten by 300.
        pulse(100, k);
        sb.push_back(model(100, k + 15));
        pulse(200, k2);
        pulse(300, k2);
        sb.push_back(model(300, k + 31));
        wait_drain(80);
        repeat (20) @(negedge clk);

        // Reset mid-conversion: no done may follow.
        pulse(4321, k);
        repeat (6) @(negedge clk);
        check("busy_before_abort", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("idle_after_abort", busy, 0);

        // Back-to-back: request sampled in the DONE cycle.
        pulse(55, k);
        sb.push_back(model(55, k + 15));
        repeat (13) @(negedge clk);
        pulse(8765, k2);
        check("b2b_edge", k2, k + 15);
        sb.push_back(model(8765, k + 31));
        wait_drain(60);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
